// File: rtl/reg_base_pkg.sv
// ============================================================================
// reg_base_pkg : shared widths/types for the 16x32 register file.
// Optional feature macro: REG_BASE_ZERO_REG_EN (register 0 hardwired to zero).
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_base_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef data_t [NUM_REGS-1:0] regfile_t;

`ifdef REG_BASE_ZERO_REG_EN
   localparam bit ZERO_REG_EN = 1'b1;
`else
   localparam bit ZERO_REG_EN = 1'b0;
`endif
endpackage

`default_nettype wire

// File: rtl/reg_base_if.sv
// ============================================================================
// reg_base_if : register-file access bus (decode side = master, regfile = slave).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface reg_base_if;
   import reg_base_pkg::*;

   logic  Read;
   logic  Write;
   addr_t Ra;
   addr_t Rb;
   data_t Data;
   data_t OutA;
   data_t OutB;

   modport master (output Read, Write, Ra, Rb, Data, input  OutA, OutB);
   modport slave  (input  Read, Write, Ra, Rb, Data, output OutA, OutB);
endinterface

`default_nettype wire

// File: rtl/reg_base_rd_port.sv
// ============================================================================
// reg_base_rd_port : one registered read port with write-first bypass and hold.
// Honours REG_BASE_ZERO_REG_EN via reg_base_pkg::ZERO_REG_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_base_rd_port
   import reg_base_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     rd_en_i,
   input  logic     wr_en_i,
   input  addr_t    rd_addr_i,
   input  addr_t    wr_addr_i,
   input  data_t    wr_data_i,
   input  regfile_t regs_i,
   output data_t    rd_data_o
);

   data_t rd_data_q;
   data_t rd_data_d;

   // Zero-register check comes first so address 0 wins even over the bypass.
   always_comb begin
      rd_data_d = regs_i[rd_addr_i];
      if (ZERO_REG_EN && (rd_addr_i == '0)) begin
         rd_data_d = '0;
      end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
         rd_data_d = wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/reg_base.sv
// ============================================================================
// reg_base : 16 x 32-bit register file, one write port, two registered read ports.
// Optional macro REG_BASE_ZERO_REG_EN makes register 0 read as zero and drop writes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_base
   import reg_base_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   reg_base_if.slave  bus_io
);

   regfile_t regs_q;
   regfile_t regs_d;
   data_t    w_out_a;
   data_t    w_out_b;

   always_comb begin
      regs_d = regs_q;
      if (bus_io.Write && !(ZERO_REG_EN && (bus_io.Ra == '0))) begin
         regs_d[bus_io.Ra] = bus_io.Data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Ra doubles as the write address, so port A always sees the bypass on a write.
   reg_base_rd_port u_rd_a (
      .clk       (clk),
      .rst       (rst),
      .rd_en_i   (bus_io.Read),
      .wr_en_i   (bus_io.Write),
      .rd_addr_i (bus_io.Ra),
      .wr_addr_i (bus_io.Ra),
      .wr_data_i (bus_io.Data),
      .regs_i    (regs_q),
      .rd_data_o (w_out_a)
   );

   reg_base_rd_port u_rd_b (
      .clk       (clk),
      .rst       (rst),
      .rd_en_i   (bus_io.Read),
      .wr_en_i   (bus_io.Write),
      .rd_addr_i (bus_io.Rb),
      .wr_addr_i (bus_io.Ra),
      .wr_data_i (bus_io.Data),
      .regs_i    (regs_q),
      .rd_data_o (w_out_b)
   );

   assign bus_io.OutA = w_out_a;
   assign bus_io.OutB = w_out_b;

endmodule

`default_nettype wire

// File: tb/tb_reg_base.sv
// ============================================================================
// tb_reg_base : directed self-checking bench for reg_base.
// Expectations for register 0 follow REG_BASE_ZERO_REG_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_base;
   import reg_base_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   reg_base_if bus ();

   reg_base dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input data_t got, input data_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input addr_t ra, input addr_t rb,
                        input data_t d);
      bus.Read  = rd;
      bus.Write = wr;
      bus.Ra    = ra;
      bus.Rb    = rb;
      bus.Data  = d;
   endtask

   task automatic wr_reg(input addr_t a, input data_t d);
      drive(1'b0, 1'b1, a, '0, d);
      step();
   endtask

   task automatic rd_pair(input addr_t ra, input addr_t rb);
      drive(1'b1, 1'b0, ra, rb, '0);
      step();
   endtask

   data_t exp_r0;
   data_t exp_r0_byp;

   initial begin
      n_checks = 0;
      n_fail   = 0;
`ifdef REG_BASE_ZERO_REG_EN
      exp_r0     = 32'd0;
      exp_r0_byp = 32'd0;
`else
      exp_r0     = 32'd99;
      exp_r0_byp = 32'd5;
`endif
      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0);
      #1;
      step();
      step();
      rst = 1'b0;
      check_val("reset_outa", bus.OutA, 32'd0);
      check_val("reset_outb", bus.OutB, 32'd0);

      for (int i = 0; i < NUM_REGS; i++) begin
         rd_pair(addr_t'(i), addr_t'(NUM_REGS - 1 - i));
         check_val($sformatf("reset_rd_a%0d", i), bus.OutA, 32'd0);
         check_val($sformatf("reset_rd_b%0d", i), bus.OutB, 32'd0);
      end

      // Write-first bypass with Ra==Rb.
      drive(1'b1, 1'b1, 4'd1, 4'd1, 32'd42);
      step();
      check_val("bypass_a", bus.OutA, 32'd42);
      check_val("bypass_b", bus.OutB, 32'd42);
      rd_pair(4'd1, 4'd1);
      check_val("stored_r1_a", bus.OutA, 32'd42);
      check_val("stored_r1_b", bus.OutB, 32'd42);

      // Bypass on A only; B reads a different stored register.
      drive(1'b1, 1'b1, 4'd2, 4'd1, 32'd77);
      step();
      check_val("bypass_split_a", bus.OutA, 32'd77);
      check_val("bypass_split_b", bus.OutB, 32'd42);

      wr_reg(4'd5, 32'hDEADBEEF);
      wr_reg(4'd9, 32'd7);
      check_val("no_read_hold_a", bus.OutA, 32'd77);
      rd_pair(4'd5, 4'd9);
      check_val("r5_a", bus.OutA, 32'hDEADBEEF);
      check_val("r9_b", bus.OutB, 32'd7);
      rd_pair(4'd15, 4'd2);
      check_val("r15_a", bus.OutA, 32'd0);
      check_val("r2_b", bus.OutB, 32'd77);
      rd_pair(4'd5, 4'd9);

      // Read low: outputs hold while addresses move.
      drive(1'b0, 1'b0, 4'd1, 4'd2, 32'hFFFF_FFFF);
      step();
      step();
      check_val("hold_a", bus.OutA, 32'hDEADBEEF);
      check_val("hold_b", bus.OutB, 32'd7);

      // Reset mid-operation discards the pending write.
      wr_reg(4'd3, 32'd123);
      rst = 1'b1;
      drive(1'b1, 1'b1, 4'd3, 4'd3, 32'd55);
      step();
      rst = 1'b0;
      check_val("midrst_a", bus.OutA, 32'd0);
      check_val("midrst_b", bus.OutB, 32'd0);
      rd_pair(4'd3, 4'd5);
      check_val("midrst_r3", bus.OutA, 32'd0);
      check_val("midrst_r5", bus.OutB, 32'd0);

      // Register 0 behaviour depends on the zero-register option.
      wr_reg(4'd0, 32'd99);
      rd_pair(4'd0, 4'd0);
      check_val("r0_a", bus.OutA, exp_r0);
      check_val("r0_b", bus.OutB, exp_r0);
      drive(1'b1, 1'b1, 4'd0, 4'd0, 32'd5);
      step();
      check_val("r0_bypass_a", bus.OutA, exp_r0_byp);
      check_val("r0_bypass_b", bus.OutB, exp_r0_byp);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
